// File: rtl/lsu_pkg.sv
// Shared types, size codes and reset values for the load/store unit.
// LSU_MISALIGN_SPLIT_EN enables splitting misaligned halfwords into two byte accesses.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_FIN  = 2'd3
  } lsu_state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam logic        RST_READY = 1'b1;
  localparam logic [15:0] RST_ADDR  = 16'h0000;
  localparam logic [15:0] RST_DATA  = 16'h0000;

  function automatic logic is_misaligned(input logic size, input logic [15:0] addr);
    return (size == SZ_HALF) && addr[0];
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: byte extraction with sign/zero extension and
// little-endian assembly of a halfword fetched as two byte accesses.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic        size,
  input  logic        sign_ext,
  input  logic        split,
  input  logic [15:0] data_out,
  input  logic [7:0]  low_byte,
  output logic [15:0] rdata
);

  always_comb begin
    rdata = data_out;
    if (split) begin
      rdata = {data_out[7:0], low_byte};
    end else if (size == SZ_BYTE) begin
      rdata = sign_ext ? {{8{data_out[7]}}, data_out[7:0]} : {8'h00, data_out[7:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a single-request CPU port to a byte/halfword memory.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned halfwords instead of rejecting them.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        wmem,
  output logic [15:0] DAddress,
  output logic [15:0] DataIn,
  output logic        memc,
  input  logic [15:0] DataOut
);

  lsu_state_e  state;
  logic        lat_write;
  logic        lat_size;
  logic        lat_signed;
  logic        lat_split;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [7:0]  low_byte;
  logic [15:0] aligned_rdata;

  // Memory-side outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      req_ready  <= RST_READY;
      wmem       <= 1'b0;
      memc       <= 1'b0;
      DAddress   <= RST_ADDR;
      DataIn     <= RST_DATA;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_split  <= 1'b0;
      lat_addr   <= RST_ADDR;
      lat_wdata  <= RST_DATA;
      low_byte   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_split  <= is_misaligned(req_size, req_addr);
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (is_misaligned(req_size, req_addr)) begin
`ifdef LSU_MISALIGN_SPLIT_EN
              state    <= ST_ACC0;
              wmem     <= req_write;
              memc     <= SZ_BYTE;
              DAddress <= req_addr;
              DataIn   <= {8'h00, req_wdata[7:0]};
`else
              state      <= ST_FIN;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
`endif
            end else begin
              state    <= ST_ACC0;
              wmem     <= req_write;
              memc     <= req_size;
              DAddress <= req_addr;
              DataIn   <= req_wdata;
            end
          end
        end

        ST_ACC0: begin
          if (lat_split) begin
            state    <= ST_ACC1;
            DAddress <= lat_addr + 16'd1;
            DataIn   <= {8'h00, lat_wdata[15:8]};
          end else begin
            state      <= ST_FIN;
            wmem       <= 1'b0;
            resp_valid <= 1'b1;
          end
        end

        // DataOut now holds the byte read by the first half of the split access.
        ST_ACC1: begin
          low_byte   <= DataOut[7:0];
          state      <= ST_FIN;
          wmem       <= 1'b0;
          resp_valid <= 1'b1;
        end

        ST_FIN: begin
          state      <= ST_IDLE;
          req_ready  <= RST_READY;
          wmem       <= 1'b0;
          memc       <= 1'b0;
          DAddress   <= RST_ADDR;
          DataIn     <= RST_DATA;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  lsu_load_align u_align (
    .size     (lat_size),
    .sign_ext (lat_signed),
    .split    (lat_split),
    .data_out (DataOut),
    .low_byte (low_byte),
    .rdata    (aligned_rdata)
  );

  // DataOut is only meaningful during FIN, so the load result is formed combinationally there.
  assign resp_rdata = (resp_valid && !resp_err && !lat_write) ? aligned_rdata : 16'h0000;

endmodule
